// File: rtl/reg_scoreboard.sv
// Register-producer scoreboard for a 5-stage pipeline. It ages each register write
// through EX/MEM/WB and answers ID-stage source queries combinationally.
module reg_scoreboard #(
    parameter int NREG = 16,
    parameter int LAT  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       issue_valid,
    input  logic [3:0] issue_rd,
    input  logic       issue_is_load,
    input  logic       br,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    output logic       rs_busy,
    output logic       rt_busy,
    output logic [1:0] rs_stage,
    output logic [1:0] rt_stage,
    output logic       stall_ld,
    output logic       stall_br,
    output logic [4:0] pending_cnt
);

    // Age encoding doubles as the stage number: 3=EX, 2=MEM, 1=WB, 0=idle.
    localparam logic [1:0] AGE_ISSUE = 2'(LAT);
    localparam logic [1:0] AGE_EX    = 2'd3;
    localparam logic [1:0] AGE_MEM   = 2'd2;

    logic [1:0]      r_age [NREG];
    logic [NREG-1:0] r_ld;
    logic [4:0]      r_pending_cnt;

    logic [1:0]      w_age_nxt [NREG];
    logic [NREG-1:0] w_ld_nxt;
    logic [4:0]      w_pending_nxt;
    logic            w_issue;

    logic [1:0]      w_rs_age;
    logic [1:0]      w_rt_age;
    logic            w_rs_ld;
    logic            w_rt_ld;

    // Writes to r0 never create an entry.
    assign w_issue = issue_valid && (issue_rd != 4'd0);

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here the decrement default comes first), so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_age_nxt[i] = (r_age[i] != 2'd0) ? (r_age[i] - 2'd1) : 2'd0;
            w_ld_nxt[i]  = r_ld[i] && (w_age_nxt[i] != 2'd0);
            // The newest producer overrides any older in-flight write of the same register.
            if (w_issue && (issue_rd == 4'(i))) begin
                w_age_nxt[i] = AGE_ISSUE;
                w_ld_nxt[i]  = issue_is_load;
            end
        end
        w_age_nxt[0] = 2'd0;
        w_ld_nxt[0]  = 1'b0;
    end

    // Count is taken on the next-state ages so pending_cnt lines up with r_age.
    always_comb begin
        w_pending_nxt = 5'd0;
        for (int i = 0; i < NREG; i++) begin
            w_pending_nxt = w_pending_nxt + {4'd0, (w_age_nxt[i] != 2'd0)};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the age/ld arrays are real tracking state, not data storage,
            // so every entry must be cleared on reset.
            for (int i = 0; i < NREG; i++) begin
                r_age[i] <= 2'd0;
            end
            r_ld          <= '0;
            r_pending_cnt <= 5'd0;
        end else if (!hold) begin
            for (int i = 0; i < NREG; i++) begin
                r_age[i] <= w_age_nxt[i];
            end
            r_ld          <= w_ld_nxt;
            r_pending_cnt <= w_pending_nxt;
        end
    end

    always_comb begin
        w_rs_age = (id_rs == 4'd0) ? 2'd0 : r_age[id_rs];
        w_rt_age = (id_rt == 4'd0) ? 2'd0 : r_age[id_rt];
        w_rs_ld  = (id_rs != 4'd0) && r_ld[id_rs];
        w_rt_ld  = (id_rt != 4'd0) && r_ld[id_rt];
    end

    assign rs_stage    = w_rs_age;
    assign rt_stage    = w_rt_age;
    assign rs_busy     = (w_rs_age != 2'd0);
    assign rt_busy     = (w_rt_age != 2'd0);
    // A load in EX cannot forward to ID in time; its consumer must wait one cycle.
    assign stall_ld    = ((w_rs_age == AGE_EX) && w_rs_ld) || ((w_rt_age == AGE_EX) && w_rt_ld);
    // WB producers are covered by register-file write-through, so only EX/MEM stall a branch.
    assign stall_br    = br && ((w_rs_age >= AGE_MEM) || (w_rt_age >= AGE_MEM));
    assign pending_cnt = r_pending_cnt;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: table-driven cycle vectors with expected
// outputs queued at drive time and popped when the outputs are sampled.
module tb_reg_scoreboard;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       issue_valid;
    logic [3:0] issue_rd;
    logic       issue_is_load;
    logic       br;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       rs_busy;
    logic       rt_busy;
    logic [1:0] rs_stage;
    logic [1:0] rt_stage;
    logic       stall_ld;
    logic       stall_br;
    logic [4:0] pending_cnt;

    reg_scoreboard #(.NREG(16), .LAT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_is_load(issue_is_load),
        .br           (br),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .rs_stage     (rs_stage),
        .rt_stage     (rt_stage),
        .stall_ld     (stall_ld),
        .stall_br     (stall_br),
        .pending_cnt  (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst;
        logic       hold;
        logic       iv;
        logic [3:0] rd;
        logic       ld;
        logic       br;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       e_rs_busy;
        logic       e_rt_busy;
        logic [1:0] e_rs_stage;
        logic [1:0] e_rt_stage;
        logic       e_stall_ld;
        logic       e_stall_br;
        logic [4:0] e_pending;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input string tag, input logic r, input logic h, input logic iv,
                                input logic [3:0] rd, input logic ld, input logic b,
                                input logic [3:0] rs, input logic [3:0] rt,
                                input logic [1:0] ers, input logic [1:0] ert,
                                input logic esld, input logic esbr, input logic [4:0] epc);
        vec_t v;
        v.tag = tag; v.rst = r; v.hold = h; v.iv = iv; v.rd = rd; v.ld = ld; v.br = b;
        v.rs = rs; v.rt = rt;
        v.e_rs_stage = ers; v.e_rt_stage = ert;
        v.e_rs_busy  = (ers != 2'd0);
        v.e_rt_busy  = (ert != 2'd0);
        v.e_stall_ld = esld; v.e_stall_br = esbr; v.e_pending = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, compare at the falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst; hold = v.hold; issue_valid = v.iv; issue_rd = v.rd;
        issue_is_load = v.ld; br = v.br; id_rs = v.rs; id_rt = v.rt;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check($sformatf("%s.rs_busy", e.tag),     8'(rs_busy),     8'(e.e_rs_busy));
        check($sformatf("%s.rt_busy", e.tag),     8'(rt_busy),     8'(e.e_rt_busy));
        check($sformatf("%s.rs_stage", e.tag),    8'(rs_stage),    8'(e.e_rs_stage));
        check($sformatf("%s.rt_stage", e.tag),    8'(rt_stage),    8'(e.e_rt_stage));
        check($sformatf("%s.stall_ld", e.tag),    8'(stall_ld),    8'(e.e_stall_ld));
        check($sformatf("%s.stall_br", e.tag),    8'(stall_br),    8'(e.e_stall_br));
        check($sformatf("%s.pending_cnt", e.tag), 8'(pending_cnt), 8'(e.e_pending));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1);
    end

    initial begin
        //            tag      rst h iv rd ld br rs rt   ers ert sld sbr pc
        tbl.push_back(mk("rst",    1, 0, 0, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0));
        tbl.push_back(mk("rst_q",  0, 0, 0, 0, 0, 0, 5, 9,  0, 0, 0, 0, 0));
        // ALU producer of R3 aging through EX/MEM/WB with a branch reading it
        tbl.push_back(mk("alu_c1", 0, 0, 1, 3, 0, 0, 3, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("alu_c2", 0, 0, 0, 0, 0, 1, 3, 0,  3, 0, 0, 1, 1));
        tbl.push_back(mk("alu_c3", 0, 0, 0, 0, 0, 1, 3, 0,  2, 0, 0, 1, 1));
        tbl.push_back(mk("alu_c4", 0, 0, 0, 0, 0, 1, 3, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("alu_c5", 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 0, 0));
        // load to R4 read as rt: load-use stall only while in EX
        tbl.push_back(mk("ld_c1",  0, 0, 1, 4, 1, 0, 0, 4,  0, 0, 0, 0, 0));
        tbl.push_back(mk("ld_c2",  0, 0, 0, 0, 0, 0, 0, 4,  0, 3, 1, 0, 1));
        tbl.push_back(mk("ld_c3",  0, 0, 0, 0, 0, 0, 0, 4,  0, 2, 0, 0, 1));
        tbl.push_back(mk("ld_c4",  0, 0, 0, 0, 0, 0, 0, 4,  0, 1, 0, 0, 1));
        tbl.push_back(mk("ld_c5",  0, 0, 0, 0, 0, 0, 0, 4,  0, 0, 0, 0, 0));
        // R6 re-issued as a load while the first write is in EX: newest wins
        tbl.push_back(mk("re_c1",  0, 0, 1, 6, 0, 0, 6, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("re_c2",  0, 0, 1, 6, 1, 0, 6, 0,  3, 0, 0, 0, 1));
        tbl.push_back(mk("re_c3",  0, 0, 0, 0, 0, 0, 6, 0,  3, 0, 1, 0, 1));
        tbl.push_back(mk("re_c4",  0, 0, 0, 0, 0, 0, 6, 0,  2, 0, 0, 0, 1));
        tbl.push_back(mk("re_c5",  0, 0, 0, 0, 0, 0, 6, 0,  1, 0, 0, 0, 1));
        tbl.push_back(mk("re_c6",  0, 0, 0, 0, 0, 0, 6, 0,  0, 0, 0, 0, 0));
        // R7 frozen by hold for three cycles; an issue to R8 during hold is dropped
        tbl.push_back(mk("hd_c1",  0, 0, 1, 7, 0, 0, 7, 8,  0, 0, 0, 0, 0));
        tbl.push_back(mk("hd_c2",  0, 1, 1, 8, 1, 0, 7, 8,  3, 0, 0, 0, 1));
        tbl.push_back(mk("hd_c3",  0, 1, 0, 0, 0, 1, 7, 8,  3, 0, 0, 1, 1));
        tbl.push_back(mk("hd_c4",  0, 1, 0, 0, 0, 0, 7, 8,  3, 0, 0, 0, 1));
        tbl.push_back(mk("hd_c5",  0, 0, 0, 0, 0, 0, 7, 8,  3, 0, 0, 0, 1));
        tbl.push_back(mk("hd_c6",  0, 0, 0, 0, 0, 0, 7, 8,  2, 0, 0, 0, 1));
        tbl.push_back(mk("hd_c7",  0, 0, 0, 0, 0, 0, 7, 8,  1, 0, 0, 0, 1));
        tbl.push_back(mk("hd_c8",  0, 0, 0, 0, 0, 0, 7, 8,  0, 0, 0, 0, 0));
        // issue to r0 is ignored
        tbl.push_back(mk("r0_c1",  0, 0, 1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk("r0_c2",  0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));

        rst = 1'b1; hold = 1'b0; issue_valid = 1'b0; issue_rd = 4'd0;
        issue_is_load = 1'b0; br = 1'b0; id_rs = 4'd0; id_rt = 4'd0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Three producers in flight, then reset (with hold and issue also asserted).
        apply(mk("rf_c1", 0, 0, 1, 1, 1, 0, 1, 2,  0, 0, 0, 0, 0));
        apply(mk("rf_c2", 0, 0, 1, 2, 0, 0, 1, 2,  3, 0, 1, 0, 1));
        apply(mk("rf_c3", 0, 0, 1, 5, 1, 1, 1, 2,  2, 3, 0, 1, 2));
        apply(mk("rf_c4", 1, 1, 1, 9, 1, 0, 5, 1,  3, 1, 1, 0, 3));
        apply(mk("rf_c5", 0, 0, 0, 0, 0, 1, 5, 9,  0, 0, 0, 0, 0));
        apply(mk("rf_c6", 0, 0, 0, 0, 0, 1, 1, 2,  0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-producer scoreboard for the 5-stage pipeline (IF, ID, EX, MEM, WB). It records every register write as the instruction leaves ID. It then ages that write through EX, MEM and WB, and answers ID-stage source-register queries from the recorded state. It is the producer-side counterpart of the branch/ALU dependence check. It supplies busy, stage, load-use stall and branch stall information, so downstream stall and forwarding logic no longer compares pipeline-register fields stage by stage.

## Interface
Parameters:
- NREG, 16: architectural register count; register ids are 4 bits.
- LAT, 3: stages a producer is tracked after ID (EX=3, MEM=2, WB=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- hold  input  1  global pipeline freeze; all state is held.
- issue_valid  input  1  an instruction moves ID->EX this cycle and writes a register.
- issue_rd  input  4  destination register of the issuing instruction.
- issue_is_load  input  1  the issuing instruction is a load.
- br  input  1  ID holds a branch that reads registers in ID.
- id_rs  input  4  ID source register 1.
- id_rt  input  4  ID source register 2.
- rs_busy  output  1  id_rs has an in-flight producer.
- rt_busy  output  1  id_rt has an in-flight producer.
- rs_stage  output  2  stage of the newest id_rs producer: 3=EX, 2=MEM, 1=WB, 0=none.
- rt_stage  output  2  same encoding for id_rt.
- stall_ld  output  1  load-use stall request.
- stall_br  output  1  branch-operand stall request.
- pending_cnt  output  5  number of registers with a nonzero age (registered).

## Operation
- State per register r: age[r] (2 bits, 0..3) and ld[r] (1 bit).
- Register 0 is hardwired zero. Issues to r0 are ignored; age[0] and ld[0] stay 0.
- Per cycle when hold=0:
  - Every nonzero age decrements by 1.
  - On issue_valid with issue_rd!=0: age[issue_rd]<=3 and ld[issue_rd]<=issue_is_load.
  - Issue overrides the decrement for that register. The newest producer always wins, including when an older producer of the same register is still in flight.
- When an age reaches 0, ld is cleared in the same update.
- hold=1: ages, ld bits and pending_cnt are frozen. issue_valid is ignored (no entry is created).
- pending_cnt is the registered population count of registers with a nonzero next age. Per cycle it changes by at most +1/-1, because at most one register is at age 1 and at most one issue occurs per cycle.
- Query outputs are combinational from current state and the id_rs/id_rt inputs:
  - rs_stage = age[id_rs].
  - rs_busy = (age[id_rs]!=0).
  - rt_stage and rt_busy are the same for id_rt.
  - Queries of r0 return 0.
- stall_ld = (age[id_rs]==3 & ld[id_rs]) | (age[id_rt]==3 & ld[id_rt]).
- stall_br = br & ((age[id_rs]>=2) | (age[id_rt]>=2)). A WB-stage producer is covered by register-file write-through and does not stall.
- The scoreboard does not gate issue itself. The ID stage must drive issue_valid=0 for bubbles, flushed slots and stalled cycles.

## Timing
- Reset values:
  - All age and ld bits are 0 and pending_cnt=0.
  - All busy, stage and stall outputs are 0, for any query.
- rst has priority over hold and issue_valid. Reset mid-flight discards all tracked producers at the next edge.
- Issue at edge N gives stage 3 visible during cycle N+1, 2 during N+2 and 1 during N+3. The entry is clear (0) from N+4 unless re-issued.
- Each hold cycle extends the current stage by one cycle.
- Query-to-output path is combinational, with zero-cycle latency.
- Same-cycle issue and query of the same register: the query sees the pre-edge state. The new producer becomes visible next cycle.

## Test plan
- Reset, then query rs=5, rt=9: all outputs 0, pending_cnt=0.
- Issue R3 (ALU) at cycle 1, with id_rs=3 held:
  - rs_stage reads 3,2,1,0 on cycles 2-5.
  - stall_ld stays 0.
  - With br=1, stall_br is 1 on cycles 2-3 and 0 on cycles 4-5.
  - pending_cnt reads 1,1,1,0.
- Load to R4 at cycle 1, id_rt=4: stall_ld=1 in cycle 2 only. rt_stage=2 in cycle 3.
- Issue R6 at cycle 1, issue R6 again (load) at cycle 2: rs_stage=3 with stall_ld=1 in cycle 3. Stage reaches 0 in cycle 6. pending_cnt never exceeds 1.
- Issue R7, assert hold for cycles 2-4, release: rs_stage stays 3 through cycle 5, then reads 2 in cycle 6. An issue_valid pulse during hold creates no entry.
- Issue R0 and query rs=0: no busy and pending_cnt=0. Assert rst while three producers are in flight: everything reads 0 next cycle.
